// File: rtl/aww_types_pkg.sv
// aww_types_pkg: shared pipeline stall encoding, hazard FSM states and constants
package aww_types_pkg;
  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    HALTED   = 2'd2
  } hazard_state_t;

  localparam int REG_ZERO = 0;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit event counter with enable that saturates at all-ones
module hazard_perf_cnt (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  output logic [31:0] count
);
  // count enabled cycles, holding at all-ones once reached
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) count <= '0;
    else if (en && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the pipeline register bank and PC.
// Optional macro HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_ctrl
  import aww_types_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             idex_mul,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             memwb_halt,
  output pipe_stall_t      pipe_stall,
  output logic             ifid_FLUSH,
  output logic             idex_FLUSH,
  output logic             pc_WEN,
  output logic             halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
  localparam logic MUL_EN = MUL_LAT > 1;

  hazard_state_t state, state_nx;
  logic [CW-1:0] mul_cnt, mul_cnt_nx;
  logic full, mul_active, load_use;

  // state and multiply counter registers
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nx;
      mul_cnt <= mul_cnt_nx;
    end

  // stall priority, redirect flushes and PC write enable
  always_comb begin
    full       = state == HALTED || (dmem_req && !dhit);
    mul_active = (state == RUN && idex_mul && MUL_EN) || (state == MUL_BUSY && mul_cnt != '0);
    load_use   = idex_memread && idex_rd != REG_W'(REG_ZERO) && (idex_rd == ifid_rs || idex_rd == ifid_rt);
    pipe_stall = full ? FULL_STALL : mul_active ? EXMEM_STALL : load_use ? IDEX_STALL : !ihit ? IFID_STALL : NO_STALL;
    idex_FLUSH = branch_taken && (pipe_stall == NO_STALL || pipe_stall == IFID_STALL);
    ifid_FLUSH = (branch_taken || jump) && pipe_stall == NO_STALL;
    pc_WEN     = pipe_stall == NO_STALL || (pipe_stall == IFID_STALL && branch_taken);
    halted     = state == HALTED;
  end

  // next state: halt wins, a full stall freezes the multiply sequence
  always_comb begin
    state_nx   = state;
    mul_cnt_nx = mul_cnt;
    if (state != HALTED && memwb_halt) state_nx = HALTED;
    else if (!full) begin
      if (state == RUN && idex_mul && MUL_EN) begin
        state_nx   = MUL_BUSY;
        mul_cnt_nx = MUL_INIT;
      end else if (state == MUL_BUSY) begin
        state_nx   = mul_cnt != '0 ? MUL_BUSY : RUN;
        mul_cnt_nx = mul_cnt != '0 ? mul_cnt - CW'(1) : mul_cnt;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (pipe_stall != NO_STALL && state != HALTED),
    .count (stall_cycles)
  );

  hazard_perf_cnt u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ifid_FLUSH || idex_FLUSH),
    .count (flush_count)
  );
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MUL_LAT=4)
module tb_hazard_ctrl;
  import aww_types_pkg::*;

  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit, dmem_req, dhit, idex_memread, idex_mul, branch_taken, jump, memwb_halt;
  logic [4:0] idex_rd, ifid_rs, ifid_rt;
  pipe_stall_t pipe_stall;
  logic ifid_FLUSH, idex_FLUSH, pc_WEN, halted;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  int n_assert = 0, n_fail = 0;
  int exp_stalls = 0, exp_flushes = 0;

  hazard_ctrl #(.MUL_LAT(4), .REG_W(5)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dmem_req     (dmem_req),
    .dhit         (dhit),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_mul     (idex_mul),
    .branch_taken (branch_taken),
    .jump         (jump),
    .memwb_halt   (memwb_halt),
    .pipe_stall   (pipe_stall),
    .ifid_FLUSH   (ifid_FLUSH),
    .idex_FLUSH   (idex_FLUSH),
    .pc_WEN       (pc_WEN),
    .halted       (halted)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ihit = 1; dmem_req = 0; dhit = 0; idex_memread = 0; idex_mul = 0;
    branch_taken = 0; jump = 0; memwb_halt = 0;
    idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic outs(input string tag, input pipe_stall_t es, input logic ei, input logic ed,
                      input logic ep, input logic eh);
    check1({tag, ".stall"}, 32'(pipe_stall), 32'(es));
    check1({tag, ".ifid_flush"}, 32'(ifid_FLUSH), 32'(ei));
    check1({tag, ".idex_flush"}, 32'(idex_FLUSH), 32'(ed));
    check1({tag, ".pc_wen"}, 32'(pc_WEN), 32'(ep));
    check1({tag, ".halted"}, 32'(halted), 32'(eh));
  endtask

  // one full cycle: settle, compare, update the perf model, advance past the next edge
  task automatic chk(input string tag, input pipe_stall_t es, input logic ei, input logic ed,
                     input logic ep, input logic eh);
    #2;
    outs(tag, es, ei, ed, ep, eh);
`ifdef HAZARD_PERF_EN
    check1({tag, ".stall_cycles"}, stall_cycles, 32'(exp_stalls));
    check1({tag, ".flush_count"}, flush_count, 32'(exp_flushes));
`endif
    if (es != NO_STALL && !eh) exp_stalls++;
    if (ei || ed) exp_flushes++;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input string tag);
    nRST = 0;
    #2;
    outs(tag, NO_STALL, 0, 0, 1, 0);
`ifdef HAZARD_PERF_EN
    check1({tag, ".stall_cycles"}, stall_cycles, 32'd0);
    check1({tag, ".flush_count"}, flush_count, 32'd0);
`endif
    exp_stalls = 0; exp_flushes = 0;
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    idle();
    do_reset("reset");
    chk("idle", NO_STALL, 0, 0, 1, 0);

    idex_memread = 1; idex_rd = 5; ifid_rt = 5;
    chk("lu_rt", IDEX_STALL, 0, 0, 0, 0);
    idex_rd = 0;
    chk("lu_r0", NO_STALL, 0, 0, 1, 0);
    idex_rd = 7; ifid_rs = 7; ifid_rt = 4;
    chk("lu_rs", IDEX_STALL, 0, 0, 0, 0);
    ifid_rs = 3;
    chk("lu_miss", NO_STALL, 0, 0, 1, 0);
    idle();

    idex_mul = 1;
    chk("mul_c0", EXMEM_STALL, 0, 0, 0, 0);
    chk("mul_c1", EXMEM_STALL, 0, 0, 0, 0);
    chk("mul_c2", EXMEM_STALL, 0, 0, 0, 0);
    chk("mul_done", NO_STALL, 0, 0, 1, 0);
    idex_mul = 0;
    chk("mul_after", NO_STALL, 0, 0, 1, 0);

    idex_mul = 1;
    chk("muld_c0", EXMEM_STALL, 0, 0, 0, 0);
    chk("muld_c1", EXMEM_STALL, 0, 0, 0, 0);
    dmem_req = 1; dhit = 0;
    chk("muld_f0", FULL_STALL, 0, 0, 0, 0);
    chk("muld_f1", FULL_STALL, 0, 0, 0, 0);
    dmem_req = 0;
    chk("muld_c2", EXMEM_STALL, 0, 0, 0, 0);
    chk("muld_done", NO_STALL, 0, 0, 1, 0);
    idex_mul = 0;

    ihit = 0; branch_taken = 1;
    chk("br_imiss", IFID_STALL, 0, 1, 1, 0);
    branch_taken = 0;
    chk("imiss", IFID_STALL, 0, 0, 0, 0);
    ihit = 1; jump = 1;
    chk("jump", NO_STALL, 1, 0, 1, 0);
    jump = 0; branch_taken = 1;
    chk("branch", NO_STALL, 1, 1, 1, 0);
    idex_memread = 1; idex_rd = 5; ifid_rt = 5;
    chk("br_lu", IDEX_STALL, 0, 0, 0, 0);

    dmem_req = 1; dhit = 0; ihit = 0;
    chk("prio_full", FULL_STALL, 0, 0, 0, 0);
    dhit = 1;
    chk("prio_dhit", IDEX_STALL, 0, 0, 0, 0);
    idle();

    idex_mul = 1;
    chk("rmul_c0", EXMEM_STALL, 0, 0, 0, 0);
    idex_mul = 0;
    do_reset("rst_mul");
    chk("rst_mul_run", NO_STALL, 0, 0, 1, 0);

    branch_taken = 1;
    chk("pre_halt_br", NO_STALL, 1, 1, 1, 0);
    branch_taken = 0; memwb_halt = 1;
    chk("halt_cyc", NO_STALL, 0, 0, 1, 0);
    memwb_halt = 0;
    chk("halted0", FULL_STALL, 0, 0, 0, 1);
    branch_taken = 1; jump = 1;
    chk("halted1", FULL_STALL, 0, 0, 0, 1);
    branch_taken = 0; jump = 0;
    chk("halted2", FULL_STALL, 0, 0, 0, 1);
    do_reset("rst_halt");
    chk("post_halt", NO_STALL, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
